// File: rtl/dtmf_defs.sv
// Shared constants for the DTMF tone divider: default counter width and
// half-period divisors for every DTMF tone at a 1 MHz system clock.
package dtmf_defs;

    localparam int CW_DEFAULT = 16;

    localparam int DIV_697  = 717;
    localparam int DIV_770  = 649;
    localparam int DIV_852  = 587;
    localparam int DIV_941  = 531;
    localparam int DIV_1209 = 414;
    localparam int DIV_1336 = 374;
    localparam int DIV_1477 = 339;
    localparam int DIV_1633 = 306;

    // What a channel does on the coming edge.
    typedef enum logic [1:0] {
        PH_IDLE,
        PH_COUNT,
        PH_EDGE
    } chan_phase_t;

endpackage

// File: rtl/tone_div_chan.sv
// One tone channel: half-period counter with an active and a pending divisor.
// A pending divisor is adopted only at a half-period boundary or while idle.
module tone_div_chan
    import dtmf_defs::*;
#(
    parameter int CW      = CW_DEFAULT,
    parameter int DIV_RST = DIV_1336
) (
    input  logic          inclk,
    input  logic          rst_n,
    input  logic          en,
    input  logic          load,
    input  logic [CW-1:0] load_div,
    output logic          outclk,
    output logic          tick,
    output logic          applied
);

    logic [CW-1:0] count;
    logic [CW-1:0] hp;
    logic [CW-1:0] pd;
    logic          pv;
    chan_phase_t   phase;

    // NOTE: default assigned first so no path leaves phase unassigned (no latch).
    always_comb begin
        phase = PH_IDLE;
        if (en && hp != '0) begin
            phase = (count == hp - CW'(1)) ? PH_EDGE : PH_COUNT;
        end
    end

    always_ff @(posedge inclk or negedge rst_n) begin
        if (!rst_n) begin
            count   <= '0;
            hp      <= CW'(DIV_RST);
            pd      <= CW'(DIV_RST);
            pv      <= 1'b0;
            outclk  <= 1'b0;
            tick    <= 1'b0;
            applied <= 1'b0;
        end else begin
            tick    <= 1'b0;
            applied <= 1'b0;
            case (phase)
                PH_COUNT: begin
                    count <= count + CW'(1);
                end
                PH_EDGE: begin
                    count  <= '0;
                    outclk <= ~outclk;
                    tick   <= 1'b1;
                    if (pv) begin
                        hp      <= pd;
                        pv      <= 1'b0;
                        applied <= 1'b1;
                    end
                end
                default: begin
                    count  <= '0;
                    outclk <= 1'b0;
                    if (pv) begin
                        hp      <= pd;
                        pv      <= 1'b0;
                        applied <= 1'b1;
                    end
                end
            endcase
            // NOTE: non-blocking, so hp above takes the old pd and this later pv write wins.
            if (load) begin
                pd <= load_div;
                pv <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/dtmf_tone_divider.sv
// Multi-channel tone clock divider: decodes divisor writes to the addressed
// channel and flags writes to channels that do not exist.
module dtmf_tone_divider
    import dtmf_defs::*;
#(
    parameter int CH      = 2,
    parameter int CW      = CW_DEFAULT,
    parameter int DIV_RST = DIV_1336
) (
    input  logic          inclk,
    input  logic          rst_n,
    input  logic [CH-1:0] en,
    input  logic          load,
    input  logic [2:0]    load_ch,
    input  logic [CW-1:0] load_div,
    output logic          load_err,
    output logic [CH-1:0] outclk,
    output logic [CH-1:0] tick,
    output logic [CH-1:0] applied
);

    logic          ch_valid;
    logic [CH-1:0] load_sel;

    assign ch_valid = int'(load_ch) < CH;

    for (genvar i = 0; i < CH; i++) begin : g_chan
        assign load_sel[i] = load && ch_valid && (load_ch == 3'(i));

        tone_div_chan #(
            .CW      (CW),
            .DIV_RST (DIV_RST)
        ) u_chan (
            .inclk    (inclk),
            .rst_n    (rst_n),
            .en       (en[i]),
            .load     (load_sel[i]),
            .load_div (load_div),
            .outclk   (outclk[i]),
            .tick     (tick[i]),
            .applied  (applied[i])
        );
    end

    always_ff @(posedge inclk or negedge rst_n) begin
        if (!rst_n) begin
            load_err <= 1'b0;
        end else begin
            load_err <= load && !ch_valid;
        end
    end

endmodule

// File: tb/tb_dtmf_tone_divider.sv
// Bench for dtmf_tone_divider: directed tone scenarios plus random traffic,
// all compared every cycle against a countdown-based behavioural model.
module tb_dtmf_tone_divider;
    import dtmf_defs::*;

    localparam int CH = 2;
    localparam int CW = CW_DEFAULT;

    logic          inclk = 1'b0;
    logic          rst_n;
    logic [CH-1:0] en;
    logic          load;
    logic [2:0]    load_ch;
    logic [CW-1:0] load_div;
    logic          load_err;
    logic [CH-1:0] outclk;
    logic [CH-1:0] tick;
    logic [CH-1:0] applied;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc;
    int app_cnt [CH];

    // Model: active half-period, pending divisor (-1 = none), cycles left to next toggle.
    int            m_hp   [CH];
    int            m_pend [CH];
    int            m_rem  [CH];
    logic [CH-1:0] m_out, m_tick, m_app;
    logic          m_err;

    dtmf_tone_divider #(
        .CH      (CH),
        .CW      (CW),
        .DIV_RST (DIV_1336)
    ) dut (
        .inclk    (inclk),
        .rst_n    (rst_n),
        .en       (en),
        .load     (load),
        .load_ch  (load_ch),
        .load_div (load_div),
        .load_err (load_err),
        .outclk   (outclk),
        .tick     (tick),
        .applied  (applied)
    );

    always #5 inclk = ~inclk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s (cycle %0d): got 0x%0h, expected 0x%0h", tag, cyc, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int c = 0; c < CH; c++) begin
            m_hp[c]   = DIV_1336;
            m_pend[c] = -1;
            m_rem[c]  = DIV_1336;
        end
        m_out  = '0;
        m_tick = '0;
        m_app  = '0;
        m_err  = 1'b0;
    endtask

    task automatic model_edge();
        for (int c = 0; c < CH; c++) begin
            m_tick[c] = 1'b0;
            m_app[c]  = 1'b0;
            if (en[c] && m_hp[c] != 0) begin
                m_rem[c] = m_rem[c] - 1;
                if (m_rem[c] == 0) begin
                    m_out[c]  = ~m_out[c];
                    m_tick[c] = 1'b1;
                    if (m_pend[c] >= 0) begin
                        m_hp[c]   = m_pend[c];
                        m_pend[c] = -1;
                        m_app[c]  = 1'b1;
                    end
                    m_rem[c] = m_hp[c];
                end
            end else begin
                m_out[c] = 1'b0;
                if (m_pend[c] >= 0) begin
                    m_hp[c]   = m_pend[c];
                    m_pend[c] = -1;
                    m_app[c]  = 1'b1;
                end
                m_rem[c] = m_hp[c];
            end
            if (load && int'(load_ch) == c) m_pend[c] = int'(load_div);
        end
        m_err = load && int'(load_ch) >= CH;
    endtask

    task automatic step();
        @(posedge inclk);
        if (rst_n) model_edge();
        #1;
        cyc++;
        check("outclk",   32'(outclk),   32'(m_out));
        check("tick",     32'(tick),     32'(m_tick));
        check("applied",  32'(applied),  32'(m_app));
        check("load_err", 32'(load_err), 32'(m_err));
        for (int c = 0; c < CH; c++) app_cnt[c] += int'(applied[c]);
    endtask

    task automatic run_to(input int target);
        while (cyc < target) step();
    endtask

    task automatic load_one(input int ch, input int div);
        load     = 1'b1;
        load_ch  = 3'(ch);
        load_div = CW'(div);
        step();
        load     = 1'b0;
    endtask

    task automatic clear_app_cnt();
        for (int c = 0; c < CH; c++) app_cnt[c] = 0;
    endtask

    // Pulse rst_n low between edges, across exactly one clock edge.
    task automatic async_reset_pulse();
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check("rst_async_outclk",  32'(outclk),  32'(0));
        check("rst_async_tick",    32'(tick),    32'(0));
        check("rst_async_applied", 32'(applied), 32'(0));
        step();
        rst_n = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n    = 1'b0;
        en       = '0;
        load     = 1'b0;
        load_ch  = '0;
        load_div = '0;
        cyc      = -3;
        clear_app_cnt();
        model_reset();
        repeat (3) step();
        check("reset_outclk",   32'(outclk),   32'(0));
        check("reset_load_err", 32'(load_err), 32'(0));

        // Free-running at the reset divisor, retune ch0 mid-period.
        rst_n = 1'b1;
        en    = '1;
        cyc   = -1;
        run_to(99);
        load_one(0, DIV_697);
        run_to(372);
        check("ch0_before_rise", 32'(outclk[0]), 32'(0));
        run_to(373);
        check("ch0_first_rise",  32'(outclk[0]),  32'(1));
        check("ch0_rise_tick",   32'(tick[0]),    32'(1));
        check("ch0_applied_717", 32'(applied[0]), 32'(1));
        check("ch1_no_applied",  32'(applied[1]), 32'(0));
        run_to(747);
        check("ch1_fall_374",    32'(outclk[1]), 32'(0));
        check("ch1_fall_tick",   32'(tick[1]),   32'(1));
        check("ch0_still_high",  32'(outclk[0]), 32'(1));
        clear_app_cnt();

        // Two writes to ch1 inside one half-period: last write wins.
        run_to(799);
        load_one(1, DIV_1209);
        run_to(899);
        load_one(1, DIV_1477);
        run_to(1089);
        check("ch0_hp717_hold",  32'(outclk[0]), 32'(1));
        run_to(1090);
        check("ch0_hp717_fall",  32'(outclk[0]), 32'(0));
        run_to(1121);
        check("ch1_applied",     32'(applied[1]), 32'(1));

        // Stop ch0 with divisor 0, then restart it from idle.
        run_to(1199);
        load_one(0, 0);
        run_to(1459);
        check("ch1_hp339_hold",  32'(outclk[1]), 32'(1));
        run_to(1460);
        check("ch1_hp339_fall",  32'(outclk[1]), 32'(0));
        check("ch1_single_applied", 32'(app_cnt[1]), 32'(1));
        run_to(1807);
        check("ch0_applied_zero", 32'(applied[0]), 32'(1));
        run_to(1900);
        check("ch0_stopped",     32'(outclk[0]), 32'(0));
        run_to(1949);
        load_one(0, DIV_941);
        step();
        check("ch0_idle_applied", 32'(applied[0]), 32'(1));
        run_to(2481);
        check("ch0_531_before",  32'(outclk[0]), 32'(0));
        run_to(2482);
        check("ch0_531_rise",    32'(outclk[0]), 32'(1));

        // Write to a channel that does not exist.
        run_to(2599);
        load_one(5, 99);
        check("load_err_pulse",  32'(load_err), 32'(1));
        step();
        check("load_err_clear",  32'(load_err), 32'(0));

        // Reset mid-period with a pending divisor on ch1.
        run_to(2699);
        load_one(1, DIV_1633);
        run_to(2750);
        async_reset_pulse();
        cyc = -1;
        clear_app_cnt();
        run_to(372);
        check("post_rst_before_rise", 32'(outclk[0]), 32'(0));
        run_to(373);
        check("post_rst_rise",   32'(outclk[0]), 32'(1));
        run_to(800);
        check("post_rst_no_applied", 32'(app_cnt[0] + app_cnt[1]), 32'(0));

        // Random traffic: short divisors, invalid channels, enable flips, resets.
        for (int i = 0; i < 3000; i++) begin
            load = ($urandom_range(0, 7) == 0);
            load_ch = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 3) == 0) load_div = CW'($urandom_range(0, 40));
            else                           load_div = CW'($urandom_range(0, 6));
            for (int c = 0; c < CH; c++) begin
                if ($urandom_range(0, 49) == 0) en[c] = ~en[c];
            end
            step();
            if ($urandom_range(0, 599) == 0) begin
                load = 1'b0;
                async_reset_pulse();
            end
        end
        load = 1'b0;
        step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/dtmf_tone_divider.md
# dtmf_tone_divider

Parametrised multi-channel clock divider producing square-wave tone clocks from the 1 MHz system clock. Each channel has its own half-period divisor, which can be reloaded at run time. A new divisor takes effect glitch-free at the next half-period boundary. The block sits in the DTMF tone path: channel 0 drives the row tone and channel 1 the column tone, and the Nios side retunes both per keypress without stopping the clocks.

## Interface
Parameters:
- CH, 2, number of independent tone channels (1..8)
- CW, 16, divisor/counter width in bits
- DIV_RST, 374, half-period divisor loaded into every channel at reset (1336 Hz at 1 MHz)

Ports:
- inclk  in  1  system clock, 1 MHz nominal; single clock domain
- rst_n  in  1  asynchronous, active-low reset
- en  in  CH  per-channel run enable, level
- load  in  1  divisor write strobe, one cycle
- load_ch  in  3  target channel index
- load_div  in  CW  new half-period divisor
- load_err  out  1  one-cycle pulse: load with load_ch >= CH was ignored
- outclk  out  CH  tone square waves
- tick  out  CH  one-cycle pulse on every outclk toggle
- applied  out  CH  one-cycle pulse when a pending divisor becomes active

## Operation
- Per-channel state:
  - count[CW], active divisor hp[CW], pending divisor pd[CW], pending flag pv.
- Reset (async, all outputs registered):
  - count=0, hp=DIV_RST, pv=0.
  - outclk=0, tick=0, applied=0, load_err=0.
- Load, on an edge with load=1:
  - load_ch < CH: pd[load_ch]<=load_div and pv<=1. A second load before the apply overwrites pd; the last write wins.
  - load_ch >= CH: nothing is stored, and load_err pulses on the next cycle.
- Run (en=1, hp>=1), each edge:
  - If count==hp-1: toggle outclk, count<=0, tick=1. If pv, also hp<=pd, pv<=0, applied=1.
  - Otherwise count<=count+1.
- Divisor semantics:
  - hp is the half-period in inclk cycles; output frequency = f_inclk/(2*hp).
  - hp=1 toggles every cycle.
- hp=0 (stopped): count is held at 0 and outclk is driven to 0. A pending divisor is applied on the next edge (applied pulses).
- Disabled (en=0): count<=0 and outclk<=0 on the next edge, with no tick. A pending divisor is applied immediately, same as hp=0.
- Simultaneous load and boundary on the same channel: the old pd (if pv) is applied and the new load becomes pending. If pv=0, the new value is pending only and is not applied this boundary.
- Counter compare uses equality only. Changing hp never leaves count>=hp, because hp changes only when count returns to 0.

## Timing
- en rising (sampled at edge E):
  - first outclk rise at edge E+hp-1; period is 2*hp cycles thereafter.
- tick is coincident with the outclk edge it marks (same register edge).
- load at edge L on an idle channel (en=0 or hp=0): applied at L+1, and hp becomes valid from L+1.
- load on a running channel: applied at the first boundary after L. Maximum latency is hp(old) cycles.
- rst_n assertion mid-period: outputs go to reset values immediately (asynchronously); pending loads are discarded.
- Deassertion is synchronised externally; the first count increment happens on the first edge with rst_n=1.

## Structure
- Package/include dtmf_defs:
  - DTMF half-period constants at 1 MHz: DIV_697=717, DIV_770=649, DIV_852=587, DIV_941=531, DIV_1209=414, DIV_1336=374, DIV_1477=339, DIV_1633=306.
  - Also holds the CW default.
- Sub-module tone_div_chan:
  - one channel (count, hp, pd, pv, outclk, tick, applied).
  - instantiated CH times via generate.
- Top level contains only the load demux/validity check and the load_err register.

## Test plan
- Reset then en=2'b11, hold: outclk[0] first rises at cycle 373, toggles every 374 cycles, and a tick pulse accompanies every toggle.
- load ch0=717 at cycle 100 while running at 374:
  - applied[0] pulses at cycle 373 with the toggle.
  - the next half-period is 717 cycles; ch1 is unaffected.
- Two loads to ch1 (414 then 339) within one half-period: only 339 is applied, with a single applied pulse.
- load_div=0 to ch0, then load_div=531: outclk[0] is held 0 after the boundary; the second load gives applied the next cycle and a first rise 531 cycles later.
- load_ch=5 with CH=2: load_err pulses for one cycle and no channel's hp changes.
- rst_n low for 1 cycle mid-period with a pending load: all outclk=0 immediately; after release hp=374 and there is no applied pulse.
